// File: rtl/ttt_input_conditioner_if.sv
// Board/start/player-select bundle between the raw panel and the input conditioner.
interface ttt_input_conditioner_if;
  logic [8:0] btn_raw;
  logic       start_raw;
  logic       player_sel_raw;
  logic [8:0] btn_pulse;
  logic       start_pulse;
  logic       player_sel;
  logic       any_press;

  modport master (
    output btn_raw, start_raw, player_sel_raw,
    input  btn_pulse, start_pulse, player_sel, any_press
  );

  modport slave (
    input  btn_raw, start_raw, player_sel_raw,
    output btn_pulse, start_pulse, player_sel, any_press
  );
endinterface

// File: rtl/ttt_input_conditioner.sv
// Synchronize, debounce and pulse-convert the tic-tac-toe panel inputs.
// Board presses are arbitrated so that one cycle never carries two moves.
module ttt_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             differ, expire;

  assign differ = sync_q[1] != level;
  assign expire = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  // High on the edge that flips level 0->1, so the pulse register lands with it.
  assign rise   = expire && !level;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (!differ) begin
        cnt <= '0;
      end else if (expire) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module ttt_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                    clk,
  input logic                    reset,
  ttt_input_conditioner_if.slave bus
);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int NUM_IN = 11;

  logic [NUM_IN-1:0] raw_vec, lvl, rise;
  logic [8:0]        board_rise, btn_next, btn_pulse_q;
  logic              start_pulse_q, any_press_q;
  logic              unused_rise;

  // Lanes 0-8 board, 9 start, 10 player select.
  assign raw_vec = {bus.player_sel_raw, bus.start_raw, bus.btn_raw};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    ttt_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  // Player select is a level; its rise strobe has no consumer.
  assign unused_rise = rise[10];

  // A rise while any board cell is already held is a chord and is dropped;
  // among simultaneous rises only the lowest index survives.
  assign board_rise = (|lvl[8:0]) ? 9'd0 : rise[8:0];
  assign btn_next   = board_rise & (~board_rise + 9'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_pulse_q   <= '0;
      start_pulse_q <= 1'b0;
      any_press_q   <= 1'b0;
    end else begin
      btn_pulse_q   <= btn_next;
      start_pulse_q <= rise[9];
      any_press_q   <= |btn_next;
    end
  end

  assign bus.btn_pulse   = btn_pulse_q;
  assign bus.start_pulse = start_pulse_q;
  assign bus.any_press   = any_press_q;
  assign bus.player_sel  = lvl[10];
endmodule

// File: tb/tb_ttt_input_conditioner.sv
// Directed bench for the input conditioner with DEBOUNCE_CYCLES = 16.
module tb_ttt_input_conditioner;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   npulse;

  ttt_input_conditioner_if bus ();

  ttt_input_conditioner #(.DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are stable 1ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles over the next n edges in which any board pulse was visible.
  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (bus.btn_pulse != 9'd0) cnt++;
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.btn_raw        = 9'd0;
    bus.start_raw      = 1'b0;
    bus.player_sel_raw = 1'b0;
    tick(3);
    chk("rst_btn_pulse",   32'(bus.btn_pulse),   32'h0);
    chk("rst_start_pulse", 32'(bus.start_pulse), 32'h0);
    chk("rst_player_sel",  32'(bus.player_sel),  32'h0);
    chk("rst_any_press",   32'(bus.any_press),   32'h0);
    reset = 1'b0;
    count_pulses(20, npulse);
    chk("idle_no_pulse", 32'(npulse), 32'd0);

    // Clean press of the centre cell, held 40 cycles.
    bus.btn_raw = 9'h010;
    count_pulses(17, npulse);
    chk("clean_early", 32'(npulse), 32'd0);
    tick(1);
    chk("clean_pulse",     32'(bus.btn_pulse), 32'h010);
    chk("clean_any_press", 32'(bus.any_press), 32'h1);
    tick(1);
    chk("clean_drop",     32'(bus.btn_pulse), 32'h0);
    chk("clean_any_drop", 32'(bus.any_press), 32'h0);
    count_pulses(21, npulse);
    chk("clean_hold", 32'(npulse), 32'd0);
    bus.btn_raw = 9'h000;
    count_pulses(25, npulse);
    chk("clean_release", 32'(npulse), 32'd0);

    // Bounce on cell 2: 3-cycle runs for 30 cycles, then steady high.
    npulse = 0;
    for (int s = 0; s < 10; s++) begin
      int c;
      bus.btn_raw = (s % 2 == 0) ? 9'h004 : 9'h000;
      count_pulses(3, c);
      npulse += c;
    end
    chk("bounce_quiet", 32'(npulse), 32'd0);
    bus.btn_raw = 9'h004;
    count_pulses(17, npulse);
    chk("bounce_early", 32'(npulse), 32'd0);
    tick(1);
    chk("bounce_pulse", 32'(bus.btn_pulse), 32'h004);
    count_pulses(5, npulse);
    chk("bounce_single", 32'(npulse), 32'd0);
    bus.btn_raw = 9'h000;
    tick(25);

    // 15-cycle glitch on cell 7 is one short of flipping.
    bus.btn_raw = 9'h080;
    count_pulses(15, npulse);
    bus.btn_raw = 9'h000;
    begin
      int c;
      count_pulses(25, c);
      npulse += c;
    end
    chk("glitch_no_pulse", 32'(npulse), 32'd0);

    // Cells 5 and 7 together: only cell 5 counts.
    bus.btn_raw = 9'h0A0;
    tick(18);
    chk("simul_pulse", 32'(bus.btn_pulse), 32'h020);
    count_pulses(30, npulse);
    chk("simul_hold", 32'(npulse), 32'd0);
    bus.btn_raw = 9'h000;
    tick(25);
    bus.btn_raw = 9'h080;
    tick(18);
    chk("simul_bit7_alone", 32'(bus.btn_pulse), 32'h080);
    bus.btn_raw = 9'h000;
    tick(25);

    // Chord: cell 8 joins while cell 0 is held.
    bus.btn_raw = 9'h001;
    tick(18);
    chk("chord_first", 32'(bus.btn_pulse), 32'h001);
    tick(5);
    bus.btn_raw = 9'h101;
    count_pulses(30, npulse);
    chk("chord_blocked", 32'(npulse), 32'd0);
    bus.btn_raw = 9'h100;
    count_pulses(25, npulse);
    chk("chord_release0", 32'(npulse), 32'd0);
    bus.btn_raw = 9'h000;
    tick(25);
    bus.btn_raw = 9'h100;
    tick(18);
    chk("chord_repress8", 32'(bus.btn_pulse), 32'h100);
    bus.btn_raw = 9'h000;
    tick(25);

    // Start with cell 1 in the same cycle; player select rises too.
    bus.btn_raw        = 9'h002;
    bus.start_raw      = 1'b1;
    bus.player_sel_raw = 1'b1;
    tick(17);
    chk("start_early",   32'(bus.start_pulse), 32'h0);
    chk("psel_early",    32'(bus.player_sel),  32'h0);
    tick(1);
    chk("start_btn1",    32'(bus.btn_pulse),   32'h002);
    chk("start_pulse",   32'(bus.start_pulse), 32'h1);
    chk("psel_rise",     32'(bus.player_sel),  32'h1);
    tick(1);
    chk("start_drop",    32'(bus.start_pulse), 32'h0);
    tick(20);
    chk("psel_held",     32'(bus.player_sel),  32'h1);
    bus.btn_raw   = 9'h000;
    bus.start_raw = 1'b0;
    tick(25);

    // Reset mid-count on cell 3; player select stays high through it.
    bus.btn_raw = 9'h008;
    count_pulses(9, npulse);
    reset = 1'b1;
    tick(1);
    chk("rstmid_no_early", 32'(npulse),          32'd0);
    chk("rstmid_btn",      32'(bus.btn_pulse),   32'h0);
    chk("rstmid_psel",     32'(bus.player_sel),  32'h0);
    chk("rstmid_any",      32'(bus.any_press),   32'h0);
    reset = 1'b0;
    count_pulses(17, npulse);
    chk("rstmid_early", 32'(npulse), 32'd0);
    tick(1);
    chk("rstmid_pulse",    32'(bus.btn_pulse),  32'h008);
    chk("rstmid_psel_up",  32'(bus.player_sel), 32'h1);
    tick(1);
    chk("rstmid_drop",     32'(bus.btn_pulse),  32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
